// File: rtl/fork_alloc_arbiter.sv
// fork_alloc_arbiter
//   Round-robin arbiter that shares the free FPU pool between fork requesters.
//   Each granted fork is split into per-child allocation handshakes, one child
//   FPU ID per transfer. Terminated FPUs are returned to the pool through the
//   free port.
//
//   Optional build macro: FORK_ARB_TIMEOUT_EN. When it is defined, a request
//   waiting for pool capacity is rejected after TIMEOUT_CYCLES cycles.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid         fork request per FPU, held until grant or reject
//   req_count         4-bit child count per requester at [4i+3:4i]
//   grant / reject    one-cycle pulses back to the requester
//   alloc_*           child allocation stream (valid/ready, parent, child, last)
//   free_valid/id     return an FPU to the pool
//   busy              FSM is not idle
//   free_count        number of free FPUs in the pool
//   err_double_free   sticky flag: free of an already-free or out-of-range ID
module fork_alloc_arbiter #(
    parameter int NUM_FPUS       = 16,
    parameter int FPU_ID_WIDTH   = 4,
    parameter int MAX_FORK       = 4,
    parameter int ROOT_FPU       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_FPUS-1:0]     req_valid,
    input  logic [4*NUM_FPUS-1:0]   req_count,
    output logic [NUM_FPUS-1:0]     grant,
    output logic [NUM_FPUS-1:0]     reject,
    output logic                    alloc_valid,
    input  logic                    alloc_ready,
    output logic [FPU_ID_WIDTH-1:0] alloc_parent,
    output logic [FPU_ID_WIDTH-1:0] alloc_child,
    output logic                    alloc_last,
    input  logic                    free_valid,
    input  logic [FPU_ID_WIDTH-1:0] free_id,
    output logic                    busy,
    output logic [FPU_ID_WIDTH:0]   free_count,
    output logic                    err_double_free
);

    typedef enum logic [1:0] {IDLE, WAIT_POOL, ALLOC, DONE} state_t;

    localparam logic [NUM_FPUS-1:0] POOL_RST = ~(NUM_FPUS'(1) << ROOT_FPU);

    function automatic logic [FPU_ID_WIDTH-1:0] lowest_free(input logic [NUM_FPUS-1:0] m);
        lowest_free = '0;
        for (int i = NUM_FPUS-1; i >= 0; i--)
            if (m[i]) lowest_free = FPU_ID_WIDTH'(i);
    endfunction

    function automatic logic [FPU_ID_WIDTH:0] popcount(input logic [NUM_FPUS-1:0] m);
        popcount = '0;
        for (int i = 0; i < NUM_FPUS; i++)
            popcount = popcount + (FPU_ID_WIDTH+1)'(m[i]);
    endfunction

    function automatic logic [FPU_ID_WIDTH-1:0] next_id(input logic [FPU_ID_WIDTH-1:0] id);
        next_id = FPU_ID_WIDTH'((int'(id) + 1) % NUM_FPUS);
    endfunction

    state_t                  state, state_nxt;
    logic [NUM_FPUS-1:0]     mask, mask_nxt;
    logic [FPU_ID_WIDTH-1:0] rr_ptr, rr_nxt;
    logic [FPU_ID_WIDTH-1:0] win_q, win_nxt;
    logic [3:0]              cnt_q, cnt_nxt;
    logic [3:0]              rem_q, rem_nxt;
    logic [FPU_ID_WIDTH-1:0] child_nxt;
    logic [NUM_FPUS-1:0]     rej_nxt;
    logic                    dbl;
    logic                    hs;
    logic                    found;
    logic [FPU_ID_WIDTH-1:0] widx;
    logic [3:0]              wcnt;
    logic                    suff_w, suff_q;
`ifdef FORK_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TW-1:0]           tmo_q, tmo_nxt;
    logic                    tmo_hit;
`endif

    assign alloc_valid  = (state == ALLOC);
    assign alloc_parent = win_q;
    assign alloc_last   = (state == ALLOC) && (rem_q == 4'd1);
    assign busy         = (state != IDLE);
    assign grant        = (state == DONE) ? (NUM_FPUS'(1) << win_q) : '0;
    assign hs           = alloc_valid && alloc_ready;

    // Round-robin scan from rr_ptr; descending loop so the smallest offset wins.
    always_comb begin
        found = 1'b0;
        widx  = '0;
        for (int k = NUM_FPUS-1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_FPUS]) begin
                found = 1'b1;
                widx  = FPU_ID_WIDTH'((int'(rr_ptr) + k) % NUM_FPUS);
            end
        end
    end

    assign wcnt   = req_count[4*int'(widx) +: 4];
    assign suff_w = int'(free_count) >= int'(wcnt);
    assign suff_q = int'(free_count) >= int'(cnt_q);

    // Pool update: handshake consumes the offered child, a legal free returns an ID.
    // The double-free check looks at the registered mask, before this cycle's edits.
    always_comb begin
        mask_nxt = mask;
        dbl      = 1'b0;
        if (hs) mask_nxt[alloc_child] = 1'b0;
        if (free_valid) begin
            if (int'(free_id) >= NUM_FPUS) dbl = 1'b1;
            else if (mask[free_id])        dbl = 1'b1;
            else                           mask_nxt[free_id] = 1'b1;
        end
    end

`ifdef FORK_ARB_TIMEOUT_EN
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    // Counts WAIT_POOL cycles; any other state holds it at zero, so entry starts clean.
    assign tmo_nxt = (state == WAIT_POOL) ? tmo_q + 1'b1 : '0;
`endif

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        win_nxt   = win_q;
        cnt_nxt   = cnt_q;
        rem_nxt   = rem_q;
        child_nxt = alloc_child;
        rej_nxt   = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    if (wcnt == 4'd0 || int'(wcnt) > MAX_FORK) begin
                        rej_nxt = NUM_FPUS'(1) << widx;
                        rr_nxt  = next_id(widx);
                    end else begin
                        win_nxt = widx;
                        cnt_nxt = wcnt;
                        rem_nxt = wcnt;
                        if (suff_w) begin
                            state_nxt = ALLOC;
                            child_nxt = lowest_free(mask_nxt);
                        end else begin
                            state_nxt = WAIT_POOL;
                        end
                    end
                end
            end
            WAIT_POOL: begin
                if (!req_valid[win_q]) begin
                    state_nxt = IDLE;
                end else if (suff_q) begin
                    state_nxt = ALLOC;
                    child_nxt = lowest_free(mask_nxt);
                end
`ifdef FORK_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rej_nxt   = NUM_FPUS'(1) << win_q;
                    rr_nxt    = next_id(win_q);
                    state_nxt = IDLE;
                end
`endif
            end
            ALLOC: begin
                if (hs) begin
                    rem_nxt = rem_q - 4'd1;
                    if (rem_q == 4'd1) state_nxt = DONE;
                    else               child_nxt = lowest_free(mask_nxt);
                end
            end
            DONE: begin
                rr_nxt    = next_id(win_q);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            mask            <= POOL_RST;
            rr_ptr          <= '0;
            win_q           <= '0;
            cnt_q           <= '0;
            rem_q           <= '0;
            alloc_child     <= '0;
            reject          <= '0;
            free_count      <= (FPU_ID_WIDTH+1)'(NUM_FPUS - 1);
            err_double_free <= 1'b0;
`ifdef FORK_ARB_TIMEOUT_EN
            tmo_q           <= '0;
`endif
        end else begin
            state           <= state_nxt;
            mask            <= mask_nxt;
            rr_ptr          <= rr_nxt;
            win_q           <= win_nxt;
            cnt_q           <= cnt_nxt;
            rem_q           <= rem_nxt;
            alloc_child     <= child_nxt;
            reject          <= rej_nxt;
            free_count      <= popcount(mask_nxt);
            err_double_free <= err_double_free | dbl;
`ifdef FORK_ARB_TIMEOUT_EN
            tmo_q           <= tmo_nxt;
`endif
        end
    end

endmodule
